// File: rtl/shift_exec_unit.sv
// Multi-cycle shift/rotate execute unit: one bit position per clock.
// Illegal ops and zero counts complete immediately with Result=B.
module shift_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] B,
  input  logic [CNTW-1:0]  shifts,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] step;
  logic [CNTW-1:0]  cnt;
  logic [2:0]       op_q;
  logic             err_q;
  logic             legal;

  assign legal = (op <= OP_ROR);

  always_comb begin
    step = work;
    unique case (op_q)
      OP_SHL:  step = {work[WIDTH-2:0], 1'b0};
      OP_SHR:  step = {1'b0, work[WIDTH-1:1]};
      OP_SHRA: step = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_ROL:  step = {work[WIDTH-2:0], work[WIDTH-1]};
      OP_ROR:  step = {work[0], work[WIDTH-1:1]};
      default: step = work;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      op_q   <= '0;
      err_q  <= 1'b0;
      Result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            work  <= B;
            cnt   <= shifts;
            op_q  <= op;
            err_q <= ~legal;
            if (legal && (shifts != '0)) begin
              state <= SHIFT;
            end else begin
              state  <= DONE;
              Result <= B;
            end
          end
        end
        SHIFT: begin
          // cnt==1 means this edge performs the final bit step
          if (cnt == CNTW'(1)) begin
            state  <= DONE;
            Result <= step;
          end
          work <= step;
          cnt  <= cnt - CNTW'(1);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && err_q;

endmodule

// File: doc/shift_exec_unit.md
SHIFT_EXEC_UNIT -- requirements
Module: shift_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter CNTW, default 5, meaning shift-count width (WIDTH = 2**CNTW).
REQ-003 The block SHALL have port clock  input  1  meaning the single rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  meaning the asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  meaning request a new operation, sampled in IDLE only.
REQ-006 The block SHALL have port op  input  3  meaning operation code: 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 illegal.
REQ-007 The block SHALL have port B  input  WIDTH  meaning the operand, captured at start.
REQ-008 The block SHALL have port shifts  input  CNTW  meaning the shift/rotate count 0..WIDTH-1, captured at start.
REQ-009 The block SHALL have port busy  output  1  meaning state is not IDLE.
REQ-010 The block SHALL have port done  output  1  meaning a one-cycle pulse when Result is valid.
REQ-011 The block SHALL have port err  output  1  meaning the completed operation had an illegal op; valid with done.
REQ-012 The block SHALL have port Result  output  WIDTH  meaning the registered result, held until the next completion.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-014 The block SHALL, on a clock edge in IDLE with start=1, capture B, shifts and op into internal registers; edge 0 is this start edge.
REQ-015 The block SHALL go from IDLE to SHIFT on the start edge when shifts!=0 and op is legal.
REQ-016 The block SHALL go from IDLE to DONE on the start edge when shifts=0 or op is illegal, loading Result=B.
REQ-017 The block SHALL, on each edge in SHIFT, move the working value by exactly one bit per op and decrement the remaining count.
REQ-018 The block SHALL take each one-bit step as: SHL zero-fill at LSB; SHR zero-fill at MSB; SHRA replicate MSB; ROL MSB into LSB; ROR LSB into MSB.
REQ-019 The block SHALL, on the edge in SHIFT that performs the last bit step (edge N for count N), go to DONE and load Result with the fully shifted value.
REQ-020 The block SHALL assert done for exactly the one cycle spent in DONE, which follows edge max(N,0) for legal ops and edge 0 for illegal ops.
REQ-021 The block SHALL drive err=1 during DONE only for illegal ops and 0 otherwise.
REQ-022 The block SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-023 The block SHALL ignore start while busy=1; a start sampled in DONE is not queued.
REQ-024 The block SHALL start a new operation on the first edge back in IDLE if start is held high continuously, giving back-to-back throughput of N+2 cycles per operation.
REQ-025 The block SHALL hold Result stable in SHIFT and IDLE, so it changes only on edges entering DONE.
REQ-026 The block SHALL ignore changes to B, op and shifts after the start edge.

Reset
REQ-027 The block SHALL, when reset=1 at any time including mid-operation, immediately force state=IDLE, busy=0, done=0, err=0, Result=0 and clear all internal registers.
REQ-028 The block SHALL, after reset deasserts, accept start on the first subsequent rising edge.

Verification
REQ-029 The bench SHALL check: SHL, B=A5A5A5A5, shifts=1 -> Result=4B4B4B4A; done in the cycle after edge 1; busy high for 2 cycles.
REQ-030 The bench SHALL check: SHL B=DEADBEEF, shifts=2 -> 7AB6FBBC; and SHR B=80000000, shifts=31 -> 00000001 with done after edge 31.
REQ-031 The bench SHALL check: SHRA B=80000000, shifts=4 -> F8000000; ROR B=12345678, shifts=8 -> 78123456; ROL B=87654321, shifts=16 -> 43218765.
REQ-032 The bench SHALL check: shifts=0, B=FFFFFFFF, any legal op -> Result=FFFFFFFF, done after edge 0, err=0; and op=110, B=12345678, shifts=8 -> Result=12345678, err=1 with done after edge 0.
REQ-033 The bench SHALL check: start re-asserted while busy with different B -> ignored, and the original result is delivered unchanged.
REQ-034 The bench SHALL check: reset pulsed during SHIFT of a 16-bit ROL -> busy, done and Result go to 0 with no clock edge, no done pulse follows, and a fresh SHL of 1 by 4 -> 00000010 completes correctly.
